// File: rtl/data_mem_slave_pkg.sv
// Shared types and limits for the data memory responder.
// State enum, latency bounds and counter width.
package dmem_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_t;

   localparam int LAT_MIN = 1;
   localparam int LAT_MAX = 15;
   localparam int CNT_W   = 4;

endpackage

// File: rtl/data_mem_slave_if.sv
// Data-port handshake bundle between core (master) and memory (slave).
// req/wr/addr/wdata/wstrb in; addr_ok/data_ok/rdata/err back.
interface data_mem_slave_if;

   logic        req;
   logic        wr;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        addr_ok;
   logic        data_ok;
   logic [31:0] rdata;
   logic        err;

   modport master (
      output req, wr, addr, wdata, wstrb,
      input  addr_ok, data_ok, rdata, err
   );

   modport slave (
      input  req, wr, addr, wdata, wstrb,
      output addr_ok, data_ok, rdata, err
   );

endinterface

// File: rtl/data_mem_slave_array.sv
// Single-port 2^ADDR_W x 32 word array, byte write enables, registered read.
// Ports: clk_i/rst_i, addr_i, we_i/be_i/wdata_i, re_i/clr_i, rdata_o.
module dmem_array #(
   parameter int ADDR_W = 12
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic              we_i,
   input  logic [3:0]        be_i,
   input  logic [31:0]       wdata_i,
   input  logic              re_i,
   input  logic              clr_i,
   output logic [31:0]       rdata_o
);

   logic [31:0] mem [2**ADDR_W];
   logic [31:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         for (int i = 0; i < 4; i++) begin
            if (be_i[i]) begin
               mem[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
         end
      end
   end

   // clr_i loads zero instead of the array word (rejected read).
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rdata_q <= '0;
      end else if (re_i) begin
         rdata_q <= clr_i ? '0 : mem[addr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_slave.sv
// Data-side memory responder with fixed LATENCY cycles to data_ok.
// Ports: clk, rst (async, high), bus (data_mem_slave_if.slave).
module data_mem_slave
   import dmem_pkg::*;
#(
   parameter int ADDR_W  = 12,
   parameter int LATENCY = 2
) (
   input logic             clk,
   input logic             rst,
   data_mem_slave_if.slave bus
);

   if (LATENCY < LAT_MIN || LATENCY > LAT_MAX) begin : g_bad_lat
      $error("data_mem_slave: LATENCY must be 1..15");
   end

   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              wr_q;
   logic [ADDR_W-1:0] idx_q;
   logic              oor_q;
   logic              err_q;

   logic              accept;
   logic [ADDR_W-1:0] bus_idx;
   logic              bus_oor;
   logic              cur_wr;
   logic [ADDR_W-1:0] cur_idx;
   logic              cur_oor;
   logic              to_resp;
   logic [31:0]       rd_data;
   logic              unused_ok;

   assign bus_idx   = bus.addr[ADDR_W+1:2];
   assign bus_oor   = |bus.addr[31:ADDR_W+2];
   assign unused_ok = &{1'b0, bus.addr[1:0]};

   assign bus.addr_ok = (state_q == IDLE) || (state_q == RESP);
   assign bus.data_ok = (state_q == RESP);
   assign accept      = bus.req && bus.addr_ok;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE, RESP: begin
            if (accept) begin
               state_d = (LATENCY == 1) ? RESP : WAIT;
               cnt_d   = CNT_INIT;
            end else begin
               state_d = IDLE;
            end
         end
         WAIT: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = RESP;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Entering RESP from WAIT uses the latched request; otherwise
   // (LATENCY==1) the request being accepted this edge.
   assign cur_wr  = (state_q == WAIT) ? wr_q  : bus.wr;
   assign cur_idx = (state_q == WAIT) ? idx_q : bus_idx;
   assign cur_oor = (state_q == WAIT) ? oor_q : bus_oor;
   assign to_resp = (state_d == RESP);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         wr_q    <= 1'b0;
         idx_q   <= '0;
         oor_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            wr_q  <= bus.wr;
            idx_q <= bus_idx;
            oor_q <= bus_oor;
         end
         if (to_resp) begin
            err_q <= cur_oor;
         end
      end
   end

   // Writes and reads never share an edge, so one address port suffices.
   dmem_array #(
      .ADDR_W (ADDR_W)
   ) u_array (
      .clk_i   (clk),
      .rst_i   (rst),
      .addr_i  (cur_idx),
      .we_i    (accept && bus.wr && !bus_oor),
      .be_i    (bus.wstrb),
      .wdata_i (bus.wdata),
      .re_i    (to_resp && !cur_wr),
      .clr_i   (cur_oor),
      .rdata_o (rd_data)
   );

   assign bus.rdata = rd_data;
   assign bus.err   = err_q;

endmodule
